axil_req_sched: RTL and testbench
=================================

Name: axil_req_sched

Overview:
- Front-end scheduler of the APB/AXI4-Lite bridge.
- Arbitrates between the AXI4-Lite write request (AW and W joined) and the read request (AR), round-robin.
- Pushes one unified command per cycle into a shared command buffer.
- Presents the buffer head to the downstream APB sequencer over a valid/ready interface.

Parameters:
- ADDR_W, 32, address width of aw_addr/ar_addr/cmd_addr
- DATA_W, 32, write data width; strobe width is DATA_W/8
- DEPTH, 4, command buffer entries; any value >= 2, power of two not required

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address accepted
- aw_addr  in  ADDR_W  write address
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted
- w_data  in  DATA_W  write data
- w_strb  in  DATA_W/8  write byte strobes
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address accepted
- ar_addr  in  ADDR_W  read address
- cmd_valid  out  1  buffer head valid
- cmd_ready  in  1  downstream consumes head
- cmd_write  out  1  1 = write command, 0 = read command
- cmd_addr  out  ADDR_W  head address
- cmd_wdata  out  DATA_W  head write data (0 for reads)
- cmd_strb  out  DATA_W/8  head strobes (0 for reads)
- level  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Write eligible: aw_valid & w_valid both high. Read eligible: ar_valid high.
- Grant is combinational, only when buffer is not full. At most one grant per cycle.
- Only one eligible: that one is granted.
- Both eligible: class opposite to last_grant wins.
- last_grant is a register, updated on every grant; reset value WRITE, so the first tie goes to read.
- Write grant: aw_ready and w_ready both high in the same cycle. Never one without the other.
- Read grant: ar_ready high.
- The ready outputs depend only on the valids, full and last_grant. There is no combinational path from cmd_ready to any ready. When full, no ready is asserted, even if cmd_ready is high that cycle.
- Push on grant; entry = {write flag, addr, wdata, strb}. Reads store wdata/strb as 0.
- Output is first-word fall-through:
  - cmd_valid = level != 0.
  - cmd_* fields are driven from the head entry.
  - Pop on cmd_valid & cmd_ready.
- Latency: a request granted in cycle N shows cmd_valid and its fields in cycle N+1.
- Pop while empty is ignored.
- Simultaneous push and pop (non-full, non-empty): level unchanged, both pointers advance.
- Pointer wrap: a pointer at DEPTH-1 returns to 0 on advance.
- level: +1 on push only, -1 on pop only, held otherwise. Never exceeds DEPTH, never underflows.
- cmd_* fields stay stable while cmd_valid is high and cmd_ready is low.
- Starvation bound: with both classes continuously requesting and space available, grants strictly alternate.
- Reset:
  - Pointers, level and last_grant (= WRITE) are cleared or set.
  - cmd_valid = 0, level = 0.
  - aw_ready/w_ready/ar_ready = 0 during the reset cycle.
  - Buffer contents are not cleared; cmd_* are don't-care while cmd_valid = 0.
- Reset asserted mid-operation drops all queued commands. The first grant after reset follows the tie rule from WRITE.

Decomposition:
- Package bridge_pkg:
  - typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t
  - packed struct cmd_t {write, addr, wdata, strb} sized from package localparams ADDR_W/DATA_W
- Sub-module cmd_buffer: synchronous FIFO of cmd_t.
  - Storage written on the clock edge.
  - FWFT head output, level/full/empty.
  - Pointer wrap at DEPTH-1.
- Arbitration, joining and last_grant live in axil_req_sched.

Test Plan:
- Reset, then ar_valid=1 with ar_addr=0x10 for one cycle, cmd_ready=0 -> ar_ready=1 in cycle 0; cycle 1: cmd_valid=1, cmd_write=0, cmd_addr=0x10, level=1.
- aw_valid=1, aw_addr=0x20, w_valid=0 for 3 cycles, then w_valid=1 with w_data=0xA5A5A5A5, w_strb=0xF -> no aw_ready until w_valid; then aw_ready=w_ready=1 in the same cycle; the entry carries the addr/data/strb.
- After reset, write and read both held valid, cmd_ready=1 -> grant order read, write, read, write; level stays <= 1.
- cmd_ready=0, five reads issued at addresses 0..4 with DEPTH=4 -> four accepted, level=4, ar_ready=0 on the fifth. Raise cmd_ready -> fifth accepted one cycle after the first pop; the pops emit addresses 0,1,2,3,4 in order.
- DEPTH=3: ten sequential reads while popping every other cycle -> in-order delivery across pointer wrap; level never exceeds 3.
- Two entries queued, assert rst for one cycle -> cmd_valid=0, level=0 the cycle after. The next tie grants read first.

Source files
------------

// File: rtl/axil_req_sched_pkg.sv
//------------------------------------------------------------------------------
// bridge_pkg: shared types for the APB/AXI4-Lite bridge request front end
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  function automatic cmd_t pack_cmd(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata,
    input logic [STRB_W-1:0] strb
  );
    cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.wdata = wdata;
    c.strb  = strb;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_req_sched_if.sv
//------------------------------------------------------------------------------
// axil_req_sched_if: AXI4-Lite request channels plus unified command output
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axil_req_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [LVL_W-1:0]  level;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, ar_valid, ar_addr, cmd_ready,
    input  aw_ready, w_ready, ar_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata,
           cmd_strb, level
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, ar_valid, ar_addr, cmd_ready,
    output aw_ready, w_ready, ar_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata,
           cmd_strb, level
  );

endinterface

`default_nettype wire

// File: rtl/axil_req_sched_cmd_buffer.sv
//------------------------------------------------------------------------------
// cmd_buffer: synchronous first-word-fall-through FIFO of bridge commands
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmd_buffer
  import bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire cmd_t             push_cmd,
  input  wire logic             pop,
  output      cmd_t             head_cmd,
  output      logic [LVL_W-1:0] level,
  output      logic             full,
  output      logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] c_full_lvl = LVL_W'(DEPTH);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Explicit wrap so non power-of-two depths index only valid slots.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_do_push = push & ~full;
    w_do_pop  = pop & ~empty;
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    head_cmd = r_mem[r_rd_ptr];
    level    = r_level;
    full     = (r_level == c_full_lvl);
    empty    = (r_level == '0);
  end

endmodule

`default_nettype wire

// File: rtl/axil_req_sched.sv
//------------------------------------------------------------------------------
// axil_req_sched: round-robin AW+W / AR arbiter feeding a FWFT command buffer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axil_req_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input wire logic  clk,
  input wire logic  rst,
  axil_req_sched_if.slave bus
);

  import bridge_pkg::*;

  localparam int LVL_W = $clog2(DEPTH + 1);

  grant_t              r_last_grant;
  logic                w_wr_elig;
  logic                w_rd_elig;
  logic                w_can_grant;
  logic                w_grant_wr;
  logic                w_grant_rd;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_strb;
  cmd_t                w_push_cmd;
  cmd_t                w_head;
  logic [LVL_W-1:0]    w_level;
  logic                w_full;
  logic                w_empty;

  // Readies depend only on valids, full and last_grant; cmd_ready never reaches them.
  always_comb begin
    w_wr_elig   = bus.aw_valid & bus.w_valid;
    w_rd_elig   = bus.ar_valid;
    w_can_grant = ~rst & ~w_full;
    w_grant_wr  = w_can_grant & w_wr_elig & (~w_rd_elig | (r_last_grant == GRANT_READ));
    w_grant_rd  = w_can_grant & w_rd_elig & (~w_wr_elig | (r_last_grant == GRANT_WRITE));
  end

  always_comb begin
    w_addr     = w_grant_wr ? bus.aw_addr : bus.ar_addr;
    w_wdata    = w_grant_wr ? bus.w_data  : '0;
    w_strb     = w_grant_wr ? bus.w_strb  : '0;
    w_push_cmd = pack_cmd(w_grant_wr, w_addr, w_wdata, w_strb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_WRITE;
    end else if (w_grant_wr) begin
      r_last_grant <= GRANT_WRITE;
    end else if (w_grant_rd) begin
      r_last_grant <= GRANT_READ;
    end
  end

  cmd_buffer #(
    .DEPTH (DEPTH)
  ) u_cmd_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (w_grant_wr | w_grant_rd),
    .push_cmd (w_push_cmd),
    .pop      (bus.cmd_ready),
    .head_cmd (w_head),
    .level    (w_level),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_comb begin
    bus.aw_ready  = w_grant_wr;
    bus.w_ready   = w_grant_wr;
    bus.ar_ready  = w_grant_rd;
    bus.cmd_valid = ~w_empty;
    bus.cmd_write = w_head.write;
    bus.cmd_addr  = w_head.addr;
    bus.cmd_wdata = w_head.wdata;
    bus.cmd_strb  = w_head.strb;
    bus.level     = w_level;
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_req_sched.sv
//------------------------------------------------------------------------------
// tb_axil_req_sched: directed stimulus with queue-based command scoreboards
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axil_req_sched;

  import bridge_pkg::*;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t exp_q4[$];
  cmd_t exp_q3[$];

  axil_req_sched_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus4 ();
  axil_req_sched_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(3)) bus3 ();

  axil_req_sched #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  axil_req_sched #(.ADDR_W(32), .DATA_W(32), .DEPTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
    cmd_t c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    c.strb  = s;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty4(input int budget, input string name);
    int n = 0;
    while (bus4.level != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(bus4.level), 64'd0);
  endtask

  // Scoreboards: a pop happens at the next edge whenever valid & ready at the falling edge.
  always @(negedge clk) begin
    if (!rst && bus4.cmd_valid && bus4.cmd_ready) begin
      if (exp_q4.size() == 0) begin
        check("d4_unexpected_pop", 64'(bus4.cmd_addr), 64'hFFFF_FFFF);
      end else begin
        cmd_t e;
        e = exp_q4.pop_front();
        check("d4_cmd_write", 64'(bus4.cmd_write), 64'(e.write));
        check("d4_cmd_addr",  64'(bus4.cmd_addr),  64'(e.addr));
        check("d4_cmd_wdata", 64'(bus4.cmd_wdata), 64'(e.wdata));
        check("d4_cmd_strb",  64'(bus4.cmd_strb),  64'(e.strb));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus3.cmd_valid && bus3.cmd_ready) begin
      if (exp_q3.size() == 0) begin
        check("d3_unexpected_pop", 64'(bus3.cmd_addr), 64'hFFFF_FFFF);
      end else begin
        cmd_t e;
        e = exp_q3.pop_front();
        check("d3_cmd_write", 64'(bus3.cmd_write), 64'(e.write));
        check("d3_cmd_addr",  64'(bus3.cmd_addr),  64'(e.addr));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    bus4.aw_valid = 1'b1; bus4.aw_addr = '0; bus4.w_valid = 1'b1; bus4.w_data = '0;
    bus4.w_strb = '0; bus4.ar_valid = 1'b1; bus4.ar_addr = '0; bus4.cmd_ready = 1'b0;
    bus3.aw_valid = 1'b0; bus3.aw_addr = '0; bus3.w_valid = 1'b0; bus3.w_data = '0;
    bus3.w_strb = '0; bus3.ar_valid = 1'b0; bus3.ar_addr = '0; bus3.cmd_ready = 1'b0;
    rst = 1'b1;

    // Reset: no ready even with every valid high
    #2;
    check("rst_aw_ready", 64'(bus4.aw_ready), 64'd0);
    check("rst_w_ready",  64'(bus4.w_ready),  64'd0);
    check("rst_ar_ready", 64'(bus4.ar_ready), 64'd0);
    step();
    step();
    check("rst_cmd_valid", 64'(bus4.cmd_valid), 64'd0);
    check("rst_level",     64'(bus4.level),     64'd0);
    bus4.aw_valid = 1'b0; bus4.w_valid = 1'b0; bus4.ar_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single read, one-cycle latency to the head
    bus4.ar_valid = 1'b1; bus4.ar_addr = 32'h10;
    #1;
    check("t1_ar_ready", 64'(bus4.ar_ready), 64'd1);
    check("t1_aw_ready", 64'(bus4.aw_ready), 64'd0);
    exp_q4.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
    step();
    bus4.ar_valid = 1'b0;
    #1;
    check("t1_cmd_valid", 64'(bus4.cmd_valid), 64'd1);
    check("t1_cmd_write", 64'(bus4.cmd_write), 64'd0);
    check("t1_cmd_addr",  64'(bus4.cmd_addr),  64'h10);
    check("t1_level",     64'(bus4.level),     64'd1);
    bus4.cmd_ready = 1'b1;
    step();
    bus4.cmd_ready = 1'b0;
    check("t1_drained", 64'(bus4.level), 64'd0);

    // AW without W is never granted; joined grant once W arrives
    bus4.aw_valid = 1'b1; bus4.aw_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_aw_wait", 64'(bus4.aw_ready), 64'd0);
      check("t2_w_wait",  64'(bus4.w_ready),  64'd0);
      step();
    end
    bus4.w_valid = 1'b1; bus4.w_data = 32'hA5A5_A5A5; bus4.w_strb = 4'hF;
    #1;
    check("t2_aw_ready", 64'(bus4.aw_ready), 64'd1);
    check("t2_w_ready",  64'(bus4.w_ready),  64'd1);
    exp_q4.push_back(mk(1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF));
    step();
    bus4.aw_valid = 1'b0; bus4.w_valid = 1'b0;
    #1;
    check("t2_cmd_write", 64'(bus4.cmd_write), 64'd1);
    check("t2_cmd_wdata", 64'(bus4.cmd_wdata), 64'hA5A5_A5A5);
    check("t2_cmd_strb",  64'(bus4.cmd_strb),  64'hF);
    bus4.cmd_ready = 1'b1;
    step();
    bus4.cmd_ready = 1'b0;

    // Round robin after reset: read, write, read, write
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus4.aw_valid = 1'b1; bus4.aw_addr = 32'h100; bus4.w_valid = 1'b1;
    bus4.w_data = 32'h1111_1111; bus4.w_strb = 4'h3;
    bus4.ar_valid = 1'b1; bus4.ar_addr = 32'h200; bus4.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_ar_ready", 64'(bus4.ar_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("t3_aw_ready", 64'(bus4.aw_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
      check("t3_w_ready",  64'(bus4.w_ready),  (i % 2 == 1) ? 64'd1 : 64'd0);
      check("t3_level",    64'(bus4.level),    (i == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) exp_q4.push_back(mk(1'b0, 32'h200, 32'h0, 4'h0));
      else            exp_q4.push_back(mk(1'b1, 32'h100, 32'h1111_1111, 4'h3));
      step();
    end
    bus4.aw_valid = 1'b0; bus4.w_valid = 1'b0; bus4.ar_valid = 1'b0;
    wait_empty4(4, "t3_drained");
    bus4.cmd_ready = 1'b0;

    // Fill to DEPTH=4, fifth read blocked until a slot frees
    for (int i = 0; i < 4; i++) begin
      bus4.ar_valid = 1'b1; bus4.ar_addr = 32'(i);
      #1;
      check("t4_fill_ready", 64'(bus4.ar_ready), 64'd1);
      exp_q4.push_back(mk(1'b0, 32'(i), 32'h0, 4'h0));
      step();
    end
    bus4.ar_addr = 32'd4;
    #1;
    check("t4_full_level", 64'(bus4.level),    64'd4);
    check("t4_full_block", 64'(bus4.ar_ready), 64'd0);
    bus4.cmd_ready = 1'b1;
    #1;
    check("t4_no_comb_path", 64'(bus4.ar_ready), 64'd0);
    step();
    check("t4_after_pop_level", 64'(bus4.level),    64'd3);
    check("t4_fifth_accept",    64'(bus4.ar_ready), 64'd1);
    exp_q4.push_back(mk(1'b0, 32'd4, 32'h0, 4'h0));
    step();
    bus4.ar_valid = 1'b0;
    check("t4_pushpop_level", 64'(bus4.level), 64'd3);
    wait_empty4(10, "t4_drained");
    bus4.cmd_ready = 1'b0;

    // DEPTH=3: ten reads, pop every other cycle, across pointer wrap
    begin
      int sent = 0;
      for (int cyc = 0; cyc < 80 && (sent < 10 || exp_q3.size() != 0); cyc++) begin
        bus3.cmd_ready = cyc[0];
        bus3.ar_valid  = (sent < 10);
        bus3.ar_addr   = 32'h30 + 32'(sent);
        #1;
        check("t5_level_max", (bus3.level <= 3) ? 64'd1 : 64'd0, 64'd1);
        if (bus3.ar_ready) begin
          exp_q3.push_back(mk(1'b0, 32'h30 + 32'(sent), 32'h0, 4'h0));
          sent++;
        end
        step();
      end
      bus3.ar_valid = 1'b0; bus3.cmd_ready = 1'b0;
      check("t5_sent",     64'(sent),          64'd10);
      check("t5_all_seen", 64'(exp_q3.size()), 64'd0);
    end

    // Reset mid-operation drops queue and restores the read-first tie
    bus4.ar_valid = 1'b1; bus4.ar_addr = 32'h40;
    step();
    bus4.ar_addr = 32'h44;
    step();
    bus4.ar_valid = 1'b0;
    check("t6_queued", 64'(bus4.level), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", 64'(bus4.cmd_valid), 64'd0);
    check("t6_rst_level", 64'(bus4.level),     64'd0);
    bus4.aw_valid = 1'b1; bus4.aw_addr = 32'h50; bus4.w_valid = 1'b1;
    bus4.w_data = 32'hDEAD_BEEF; bus4.w_strb = 4'h5;
    bus4.ar_valid = 1'b1; bus4.ar_addr = 32'h60;
    #1;
    check("t6_tie_ar_ready", 64'(bus4.ar_ready), 64'd1);
    check("t6_tie_aw_ready", 64'(bus4.aw_ready), 64'd0);
    exp_q4.push_back(mk(1'b0, 32'h60, 32'h0, 4'h0));
    step();
    bus4.aw_valid = 1'b0; bus4.w_valid = 1'b0; bus4.ar_valid = 1'b0;
    bus4.cmd_ready = 1'b1;
    wait_empty4(4, "t6_drained");
    bus4.cmd_ready = 1'b0;
    step();

    check("end_q4_empty", 64'(exp_q4.size()), 64'd0);
    check("end_q3_empty", 64'(exp_q3.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
